msrv32_imm_decode_ctrl: RTL and testbench



---
 rtl/msrv32_imm_decode_ctrl_if.sv | 31 +++
 rtl/msrv32_imm_decode_ctrl.sv | 142 ++++++++++++++
 tb/tb_msrv32_imm_decode_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/msrv32_imm_decode_ctrl_if.sv
// Handshake and bus bundle for msrv32_imm_decode_ctrl.
// The slave side is the decoder and the master side is its environment.
interface msrv32_imm_decode_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush_in;
  logic             in_valid_in;
  logic             in_ready_out;
  logic [31:0]      instr_in;
  logic [XLEN-1:0]  pc_in;
  logic             out_valid_out;
  logic             out_ready_in;
  logic [24:0]      instr_out;
  logic [2:0]       imm_type_out;
  logic [XLEN-1:0]  pc_out;
  logic             illegal_out;
  logic [CNT_W-1:0] stall_cnt_out;

  modport slave (
    input  flush_in, in_valid_in, instr_in, pc_in, out_ready_in,
    output in_ready_out, out_valid_out, instr_out, imm_type_out, pc_out,
           illegal_out, stall_cnt_out
  );

  modport master (
    output flush_in, in_valid_in, instr_in, pc_in, out_ready_in,
    input  in_ready_out, out_valid_out, instr_out, imm_type_out, pc_out,
           illegal_out, stall_cnt_out
  );
endinterface

// File: rtl/msrv32_imm_decode_ctrl.sv
// Decode-stage sequencer: 2-entry skid buffer that classifies opcodes into imm_type for the immediate generator.
// Optional downstream stall counter is enabled by defining MSRV32_DEC_STALL_CNT_EN.
module msrv32_imm_decode_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  msrv32_imm_decode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t          state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [24:0]     head_instr_reg;
  logic [2:0]      head_type_reg;
  logic [XLEN-1:0] head_pc_reg;
  logic            head_ill_reg;
  logic [24:0]     tail_instr_reg;
  logic [2:0]      tail_type_reg;
  logic [XLEN-1:0] tail_pc_reg;
  logic            tail_ill_reg;

  logic            accept;
  logic            pop;
  logic [2:0]      dec_type;
  logic            dec_illegal;

  assign accept = bus.in_valid_in && in_ready_reg;
  assign pop    = out_valid_reg && bus.out_ready_in;

  always_comb begin
    dec_type    = 3'b000;
    dec_illegal = 1'b0;
    case (bus.instr_in[6:0])
      7'b0110111, 7'b0010111: dec_type = 3'b100;
      7'b1101111:             dec_type = 3'b101;
      7'b1100111, 7'b0000011,
      7'b0010011, 7'b0001111: dec_type = 3'b001;
      7'b0100011:             dec_type = 3'b010;
      7'b1100011:             dec_type = 3'b011;
      7'b0110011:             dec_type = 3'b000;
      // ECALL/EBREAK carry an I-type immediate; the CSR forms need the zimm layout.
      7'b1110011:             dec_type = (bus.instr_in[14:12] != 3'b000) ? 3'b110 : 3'b001;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      head_instr_reg <= '0;
      head_type_reg  <= '0;
      head_pc_reg    <= '0;
      head_ill_reg   <= 1'b0;
      tail_instr_reg <= '0;
      tail_type_reg  <= '0;
      tail_pc_reg    <= '0;
      tail_ill_reg   <= 1'b0;
    end else if (bus.flush_in) begin
      // Data registers keep their contents; only occupancy is discarded.
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_instr_reg <= bus.instr_in[31:7];
            head_type_reg  <= dec_type;
            head_pc_reg    <= bus.pc_in;
            head_ill_reg   <= dec_illegal;
            out_valid_reg  <= 1'b1;
            state_reg      <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_instr_reg <= bus.instr_in[31:7];
            head_type_reg  <= dec_type;
            head_pc_reg    <= bus.pc_in;
            head_ill_reg   <= dec_illegal;
          end else if (accept) begin
            tail_instr_reg <= bus.instr_in[31:7];
            tail_type_reg  <= dec_type;
            tail_pc_reg    <= bus.pc_in;
            tail_ill_reg   <= dec_illegal;
            in_ready_reg   <= 1'b0;
            state_reg      <= TWO;
          end else if (pop) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_instr_reg <= tail_instr_reg;
            head_type_reg  <= tail_type_reg;
            head_pc_reg    <= tail_pc_reg;
            head_ill_reg   <= tail_ill_reg;
            in_ready_reg   <= 1'b1;
            state_reg      <= ONE;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_out  = in_ready_reg;
  assign bus.out_valid_out = out_valid_reg;
  assign bus.instr_out     = head_instr_reg;
  assign bus.imm_type_out  = head_type_reg;
  assign bus.pc_out        = head_pc_reg;
  assign bus.illegal_out   = head_ill_reg;

`ifdef MSRV32_DEC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Saturating count of cycles the head waited on downstream; flush leaves it alone.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_reg && !bus.out_ready_in && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.stall_cnt_out = stall_cnt_reg;
`else
  assign bus.stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_imm_decode_ctrl.sv
// Self-checking bench for msrv32_imm_decode_ctrl: directed scenarios plus random traffic against a queue model.
module tb_msrv32_imm_decode_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv32_imm_decode_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  msrv32_imm_decode_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  ent_t             q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] stall_exp = '0;

  // Returns {illegal, imm_type} straight from the opcode table.
  function automatic logic [3:0] ref_decode(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'h37, 7'h17:               return 4'b0100;
      7'h6F:                      return 4'b0101;
      7'h67, 7'h03, 7'h13, 7'h0F: return 4'b0001;
      7'h23:                      return 4'b0010;
      7'h63:                      return 4'b0011;
      7'h33:                      return 4'b0000;
      7'h73:                      return (ins[14:12] != 3'd0) ? 4'b0110 : 4'b0001;
      default:                    return 4'b1000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic [3:0]  d;
    logic [31:0] hi;
    check("out_valid", 64'(bus.out_valid_out), 64'(q.size() > 0));
    check("in_ready", 64'(bus.in_ready_out), 64'(q.size() < 2));
    if (q.size() > 0) begin
      d  = ref_decode(q[0].instr);
      hi = q[0].instr >> 7;
      check("instr_out", 64'(bus.instr_out), 64'(hi));
      check("imm_type", 64'(bus.imm_type_out), 64'(d[2:0]));
      check("pc_out", 64'(bus.pc_out), 64'(q[0].pc));
      check("illegal", 64'(bus.illegal_out), 64'(d[3]));
    end
    check("stall_cnt", 64'(bus.stall_cnt_out), 64'(stall_exp));
  endtask

  // One clock of stimulus: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input logic ordy, input logic fl);
    int sz;
    bit acc;
    bit pp;
    bus.in_valid_in  = iv;
    bus.instr_in     = ins;
    bus.pc_in        = pc;
    bus.out_ready_in = ordy;
    bus.flush_in     = fl;
    @(posedge clk);
    sz  = q.size();
    acc = iv && (sz < 2) && !fl;
    pp  = (sz > 0) && ordy && !fl;
`ifdef MSRV32_DEC_STALL_CNT_EN
    if (sz > 0 && !ordy && stall_exp != {CNT_W{1'b1}}) stall_exp++;
`endif
    if (fl) begin
      $display("flush: %0d entries discarded", sz);
      q.delete();
    end else begin
      if (pp) begin
        $display("pop  instr=%08h pc=%08h", q[0].instr, q[0].pc);
        void'(q.pop_front());
      end
      if (acc) q.push_back('{instr: ins, pc: pc});
    end
    #1;
    check_outputs();
  endtask

  logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h23, 7'h63, 7'h73};
  logic [31:0] seq_ins  [4] = '{32'h12345037, 32'h00C0006F, 32'hFE208EE3, 32'h00112223};
  logic [2:0]  seq_type [4] = '{3'b100, 3'b101, 3'b011, 3'b010};

  initial begin
    logic [31:0] ins;
    bus.in_valid_in  = 1'b0;
    bus.instr_in     = '0;
    bus.pc_in        = '0;
    bus.out_ready_in = 1'b0;
    bus.flush_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid_out), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready_out), 64'd1);
    check("rst_instr", 64'(bus.instr_out), 64'd0);
    check("rst_type", 64'(bus.imm_type_out), 64'd0);
    check("rst_pc", 64'(bus.pc_out), 64'd0);
    check("rst_illegal", 64'(bus.illegal_out), 64'd0);
    check("rst_stall", 64'(bus.stall_cnt_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single addi then drain
    step(1'b1, 32'h00A00093, 32'h100, 1'b1, 1'b0);
    check("addi_type", 64'(bus.imm_type_out), 64'b001);
    check("addi_instr", 64'(bus.instr_out), 64'h0001_4001);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back stream with downstream always ready
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq_ins[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      check("seq_type", 64'(bus.imm_type_out), 64'(seq_type[i]));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: third instruction held upstream until space frees
    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    check("full_ready", 64'(bus.in_ready_out), 64'd0);
    step(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b1, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // SYSTEM variants and an unknown opcode
    step(1'b1, 32'h30501073, 32'h400, 1'b1, 1'b0);
    check("csrrw_type", 64'(bus.imm_type_out), 64'b110);
    step(1'b1, 32'h00000073, 32'h404, 1'b1, 1'b0);
    check("ecall_type", 64'(bus.imm_type_out), 64'b001);
    step(1'b1, 32'h0000007F, 32'h408, 1'b1, 1'b0);
    check("bad_illegal", 64'(bus.illegal_out), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with two buffered and a competing input
    step(1'b1, 32'h00500293, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h504, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 32'h508, 1'b1, 1'b1);
    check("flush_valid", 64'(bus.out_valid_out), 64'd0);
    check("flush_ready", 64'(bus.in_ready_out), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 9) < 7), ins, $urandom, 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
    end

    // Downstream stall then asynchronous reset mid-stall
    step(1'b1, 32'h00800413, 32'h600, 1'b0, 1'b0);
    repeat (5) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    stall_exp = '0;
    check("arst_valid", 64'(bus.out_valid_out), 64'd0);
    check("arst_ready", 64'(bus.in_ready_out), 64'd1);
    check("arst_stall", 64'(bus.stall_cnt_out), 64'd0);
    check("arst_type", 64'(bus.imm_type_out), 64'd0);
    #2 rst = 1'b0;
    step(1'b1, 32'h00900493, 32'h700, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
